// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder.
package cla_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cla_seq_state_t;

   function automatic int nib_count(input int width);
      return width / NIB_W;
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice: generate/propagate per
// bit, carries expanded from c0 so no carry ripples through sum logic.
module cla4_slice
   import cla_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             c0,
   output logic [NIB_W-1:0] s,
   output logic             c4
);

   logic [NIB_W-1:0] g;
   logic [NIB_W-1:0] p;
   logic [NIB_W-1:0] c;

   always_comb begin
      g = a & b;
      p = a ^ b;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      s    = p ^ c;
   end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder around a single cla4_slice, with valid/ready on
// both sides. Define CLA_SEQ_SUB_EN to add the op_sub port (a - b).
module cla_seq_adder_ctrl
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
   input  logic             op_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIB   = nib_count(WIDTH);
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
   end

   cla_seq_state_t   state;
   cla_seq_state_t   state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
   logic             out_valid_reg;
   logic             accept;
   logic             shift_en;
   logic             last_nib;
   logic             release_res;
   logic [NIB_W-1:0] slice_s;
   logic             slice_c4;
   logic [WIDTH+NIB_W-1:0] sum_shift;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

   cla4_slice u_slice (
      .a  (op_a[NIB_W-1:0]),
      .b  (op_b[NIB_W-1:0]),
      .c0 (carry),
      .s  (slice_s),
      .c4 (slice_c4)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)      state_next = RUN;
         RUN:     if (last_nib)    state_next = DONE;
         DONE:    if (release_res) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (state == IDLE) & ~rst;
      accept      = in_valid & in_ready;
      shift_en    = (state == RUN);
      last_nib    = shift_en && (cnt == CNT_W'(NIB - 1));
      release_res = (state == DONE) & out_ready;
   end

   // Subtraction reuses the adder as a + ~b + 1; cin is ignored in that mode.
   always_comb begin
`ifdef CLA_SEQ_SUB_EN
      b_load     = op_sub ? ~b : b;
      carry_load = op_sub ? 1'b1 : cin;
`else
      b_load     = b;
      carry_load = cin;
`endif
      sum_shift  = {slice_s, sum_reg};
   end

   // Each slice nibble enters at the MSB end so nibble 0 lands at the bottom
   // after NIB shifts.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         op_a          <= '0;
         op_b          <= '0;
         carry         <= 1'b0;
         sum_reg       <= '0;
         cout_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (accept) begin
         op_a  <= a;
         op_b  <= b_load;
         carry <= carry_load;
         cnt   <= '0;
      end else if (shift_en) begin
         op_a    <= op_a >> NIB_W;
         op_b    <= op_b >> NIB_W;
         carry   <= slice_c4;
         cnt     <= cnt + 1'b1;
         sum_reg <= sum_shift[WIDTH+NIB_W-1:NIB_W];
         if (last_nib) begin
            cout_reg      <= slice_c4;
            out_valid_reg <= 1'b1;
         end
      end else if (release_res) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign sum       = sum_reg;
   assign cout      = cout_reg;

endmodule
